// File: rtl/mem_fill_ctrl.sv
// ---------------------------------------------------------------------------
// mem_fill_ctrl
//
// Fill engine for the 2114-style video/bullet RAMs. A start pulse in IDLE
// captures base/len/fill. The engine then writes the fill byte to len
// consecutive addresses, wrapping modulo 2^AW, one location per clock.
// While idle (and in the DONE cycle) the RAM port is a straight pass-through
// of the CPU bus. While busy the engine owns the port and the CPU is stalled.
//
// Optional feature macro: MEM_FILL_VERIFY_EN
//   defined   : after the fill the range is read back (VERIFY + DRAIN states)
//               and the first location whose data differs from the fill byte
//               is reported on err/err_addr (sticky until next start/reset).
//   undefined : FILL goes straight to DONE; err and err_addr are tied to 0.
//
// Handshake: start is a single-cycle request honoured only in IDLE; it is
// neither queued nor acknowledged otherwise. done is a one-cycle pulse.
// busy/cpu_stall stay high for every cycle the engine drives the RAM port.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start/base/len/fill request and its captured parameters
//   busy, done          engine status (registered)
//   err, err_addr       first verify mismatch (registered, sticky)
//   cpu_addr/din/we/q   host side of the RAM mux; cpu_stall mirrors busy
//   ram_addr/data/we/q  RAM side; ram_q is valid one cycle after ram_addr
//   dbg_state           current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module mem_fill_ctrl #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_stall,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_cur;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_fill;
    logic [AW:0]   w_len_sat;
    logic          w_last;

`ifdef MEM_FILL_VERIFY_EN
    logic [AW-1:0] r_base;
    logic [AW:0]   r_len;
    logic          r_rd_vld;     // ram_q this cycle answers a verify read
    logic [AW-1:0] r_pipe_addr;  // address that the current ram_q belongs to
    logic          r_err;
    logic [AW-1:0] r_err_addr;
`endif

    // A full-size request covers every location exactly once.
    assign w_len_sat = (len > FULL) ? FULL : len;
    assign w_last    = (r_cnt == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur       <= '0;
            r_cnt       <= '0;
            r_fill      <= '0;
`ifdef MEM_FILL_VERIFY_EN
            r_base      <= '0;
            r_len       <= '0;
            r_rd_vld    <= 1'b0;
            r_pipe_addr <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur  <= base;
                        r_cnt  <= w_len_sat;
                        r_fill <= fill;
`ifdef MEM_FILL_VERIFY_EN
                        r_base     <= base;
                        r_len      <= w_len_sat;
                        r_err      <= 1'b0;
                        r_err_addr <= '0;
`endif
                        if (w_len_sat == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    r_cur <= r_cur + 1'b1;
                    r_cnt <= r_cnt - ONE;
                    if (w_last) begin
`ifdef MEM_FILL_VERIFY_EN
                        r_state <= S_VERIFY;
                        r_cur   <= r_base;
                        r_cnt   <= r_len;
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef MEM_FILL_VERIFY_EN
                S_VERIFY: begin
                    r_cur       <= r_cur + 1'b1;
                    r_cnt       <= r_cnt - ONE;
                    r_rd_vld    <= 1'b1;
                    r_pipe_addr <= r_cur;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only the compare of the final read happens here.
                    r_rd_vld <= 1'b0;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

`ifdef MEM_FILL_VERIFY_EN
            // First mismatch wins; later ones leave err_addr alone.
            if (r_rd_vld && (ram_q != r_fill) && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= r_pipe_addr;
            end
`endif
        end
    end

    // RAM port mux. The engine write is gated by reset so that an abort
    // leaves only the locations written before the reset cycle.
    assign ram_addr = r_busy ? r_cur  : cpu_addr;
    assign ram_data = r_busy ? r_fill : cpu_din;
    assign ram_we   = r_busy ? ((r_state == S_FILL) && !reset) : cpu_we;

    assign cpu_q     = ram_q;
    assign cpu_stall = r_busy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

`ifdef MEM_FILL_VERIFY_EN
    assign err      = r_err;
    assign err_addr = r_err_addr;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_fill_ctrl
//
// Bench for mem_fill_ctrl. A behavioural RAM (registered read address) sits on
// the ram_* port. For every request the reference model derives the list of
// writes, the list of verify reads, the done cycle and the error result from
// the request parameters alone, and pushes them into expected queues. A
// negedge monitor pops and compares whenever the DUT writes, reads (verify
// build) or pulses done. Build with +define+MEM_FILL_VERIFY_EN to exercise
// the read-back path.
// ---------------------------------------------------------------------------
module tb_mem_fill_ctrl;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int N  = 2048;
`ifdef MEM_FILL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill = '0;
    logic          busy, done, err;
    logic [AW-1:0] err_addr;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_q;
    logic          cpu_stall;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_fill_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .fill(fill), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_q(cpu_q), .cpu_stall(cpu_stall), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .dbg_state(dbg_state)
    );

    // ---------------- RAM and reference memory ----------------
    logic [DW-1:0] mem [N];
    logic [DW-1:0] ref_mem [N];
    bit            corrupt [N];   // flips bit 0 of the read data at that address
    logic [AW-1:0] ra = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ra <= ram_addr;
    end
    assign ram_q = mem[ra] ^ {7'b0, corrupt[ra]};

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [34:0] exp_wr_q[$];    // {cycle[15:0], addr, data}
    logic [26:0] exp_rd_q[$];    // {cycle[15:0], addr}
    logic [27:0] exp_done_q[$];  // {cycle[15:0], err, err_addr}

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [34:0] ew;
        logic [26:0] er;
        logic [27:0] ed;
        if (!reset) begin
            if (busy && ram_we) begin
                if (exp_wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_extra act=%0h:%0h exp=none", ram_addr, ram_data);
                end else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr", {cyc[15:0], ram_addr, ram_data}, ew);
                    chk("stall", cpu_stall, 1'b1);
                end
            end
            if (busy && !ram_we && exp_rd_q.size() != 0) begin
                er = exp_rd_q.pop_front();
                chk("rd", {cyc[15:0], ram_addr}, er);
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_extra act=%0d exp=none", cyc);
                end else begin
                    ed = exp_done_q.pop_front();
                    chk("done_cyc", cyc[15:0], ed[27:12]);
                    chk("err", err, ed[11]);
                    chk("err_addr", err_addr, ed[10:0]);
                    chk("done_busy", {busy, cpu_stall}, 2'b00);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int sat_len(input logic [AW:0] l);
        return (l > (AW+1)'(N)) ? N : int'(l);
    endfunction

    task automatic do_op(input logic [AW-1:0] b, input logic [AW:0] l,
                         input logic [DW-1:0] f, input bit restart);
        int L, lat, s, rel;
        bit e;
        logic [AW-1:0] ea, a;
        L = sat_len(l);
        @(posedge clk); #1;
        base = b; len = l; fill = f; start = 1'b1; cpu_we = 1'b0;
        s = cyc;
        e = 1'b0; ea = '0;
        for (int i = 0; i < L; i++) begin
            a = b + AW'(i);
            exp_wr_q.push_back({16'(s + 1 + i), a, f});
            ref_mem[a] = f;
        end
        if (VER) begin
            for (int i = 0; i < L; i++) begin
                a = b + AW'(i);
                exp_rd_q.push_back({16'(s + L + 1 + i), a});
                if (corrupt[a] && !e) begin
                    e = 1'b1; ea = a;
                end
            end
        end
        lat = (L == 0) ? 1 : (VER ? 2 * L + 2 : L + 1);
        exp_done_q.push_back({16'(s + lat), e, ea});
        for (int k = 0; k < lat + 20; k++) begin
            @(posedge clk); #1;
            rel = cyc - s;
            start = restart && (rel == 2);
            cpu_addr = AW'($urandom);
            cpu_din  = DW'($urandom);
            cpu_we   = (rel >= 1 && rel < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_done_q.size() == 0)
                break;
        end
        start = 1'b0; cpu_we = 1'b0;
        chk("queues_drained", exp_wr_q.size() + exp_rd_q.size() + exp_done_q.size(), 0);
        exp_wr_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
    endtask

    task automatic cpu_read(input string nm, input logic [AW-1:0] a);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = a;
        @(posedge clk); #1;
        chk(nm, cpu_q, ref_mem[a]);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        ref_mem[a] = d;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [AW-1:0] b;
        int s, L;
        for (int i = 0; i < N; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
            corrupt[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, '0);
        chk("rst_stall", cpu_stall, 1'b0);
        reset = 1'b0;

        // Idle pass-through of host traffic.
        cpu_addr = 11'h155; cpu_din = 8'h5A; cpu_we = 1'b1;
        #1;
        chk("pt_addr", ram_addr, 11'h155);
        chk("pt_data", ram_data, 8'h5A);
        chk("pt_we", ram_we, 1'b1);
        ref_mem[11'h155] = 8'h5A;
        @(posedge clk); #1;
        cpu_we = 1'b0;
        cpu_read("rd_155", 11'h155);

        // Basic fill from address 0.
        do_op(11'h000, 12'd16, 8'hA5, 1'b0);
        cpu_read("rd_00f", 11'h00F);
        cpu_read("rd_010", 11'h010);

        // Wrap across the top of the address space.
        do_op(11'h7FE, 12'd4, 8'h3C, 1'b0);
        cpu_read("rd_7fe", 11'h7FE);
        cpu_read("rd_001", 11'h001);
        cpu_read("rd_002", 11'h002);

        // Corrupted read-back at base+3 and base+5.
        b = 11'h123;
        corrupt[b + 11'd3] = 1'b1;
        corrupt[b + 11'd5] = 1'b1;
        do_op(b, 12'd8, 8'h55, 1'b0);
        corrupt[b + 11'd3] = 1'b0;
        corrupt[b + 11'd5] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("err_hold", err, VER);
        chk("err_addr_hold", err_addr, VER ? b + 11'd3 : 11'd0);

        // Zero length, then a second start while busy.
        do_op(11'h400, 12'd0, 8'hEE, 1'b0);
        do_op(11'h200, 12'd5, 8'h77, 1'b1);

        // Reset during fill cycle 3 of a len=10 request.
        b = 11'h300;
        @(posedge clk); #1;
        base = b; len = 12'd10; fill = 8'hC3; start = 1'b1;
        s = cyc;
        for (int i = 0; i < 2; i++) begin
            exp_wr_q.push_back({16'(s + 1 + i), b + AW'(i), 8'hC3});
            ref_mem[b + AW'(i)] = 8'hC3;
        end
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err, 1'b0);
        cpu_addr = b + 11'd7; cpu_din = 8'h99; cpu_we = 1'b1;
        ref_mem[b + 11'd7] = 8'h99;
        @(posedge clk); #1; cpu_we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_q", exp_wr_q.size() + exp_done_q.size(), 0);
        exp_wr_q.delete(); exp_done_q.delete();
        cpu_read("abort_rd0", b);
        cpu_read("abort_rd1", b + 11'd1);
        cpu_read("abort_rd2", b + 11'd2);
        cpu_read("abort_rd7", b + 11'd7);

        // Randomized requests with random host traffic and corruption.
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom);
            L = $urandom_range(1, 40);
            for (int c = 0; c < int'($urandom_range(0, 2)); c++)
                corrupt[b + AW'($urandom_range(0, L - 1))] = 1'b1;
            do_op(b, 12'(L), DW'($urandom), 1'b0);
            for (int i = 0; i < N; i++) corrupt[i] = 1'b0;
            cpu_write(AW'($urandom), DW'($urandom));
            cpu_read("rand_rd", b + AW'($urandom_range(0, L)));
        end

        // Whole-memory fill, then a saturating oversize length.
        b = AW'($urandom);
        do_op(b, 12'd2048, 8'h69, 1'b0);
        cpu_read("full_rd", b - 11'd1);
        b = AW'($urandom);
        do_op(b, 12'd3000, 8'h96, 1'b0);
        cpu_read("sat_rd", b + 11'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
